regfile_gen: RTL and testbench
==============================

Name: regfile_gen

Overview:
- Parametrised successor to the core's fixed 4x16 register file (A, D, SP, RA).
- Generalised to WIDTH bits and NREGS registers, with a synchronous reset and an explicit write port.
- Adds write-to-read bypass, a two-phase wide immediate load, and a hardware stack-pointer unit with sticky wrap detection.
- Sits between the instruction decoder (selects, immediates, SP ops) and the ALU (operands X/Y/T, result back on wr_data).

Parameters:
- WIDTH, 16, register data width; legal range 8..32.
- NREGS, 4, number of registers; power of 2, minimum 4.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads always return stored value.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- rx_sel  in  $clog2(NREGS)  read select, port X.
- ry_sel  in  $clog2(NREGS)  read select, port Y.
- t_sel  in  $clog2(NREGS)  read select, port T.
- wr_en  in  1  register write strobe.
- wr_sel  in  $clog2(NREGS)  write target.
- wr_data  in  WIDTH  write data (ALU result).
- imm_valid  in  1  immediate load into A this cycle.
- imm_hi  in  1  0 = low phase, 1 = high phase of the immediate.
- imm_data  in  15  immediate payload (instruction[14:0]).
- sp_op  in  2  00 none, 01 push (pre-decrement), 10 pop (post-increment), 11 reserved (no-op).
- rx_data  out  WIDTH  operand X.
- ry_data  out  WIDTH  operand Y.
- t_data  out  WIDTH  target value.
- sp_data  out  WIDTH  current SP (always the stored value, never bypassed).
- sp_addr  out  WIDTH  stack memory address for this cycle's sp_op.
- sp_wrap  out  1  sticky SP wrap flag.
- imm_pend  out  1  high while a low-phase immediate awaits its high phase.

Behaviour:
- rst at a clock edge:
  - all registers, sp_wrap, imm_pend and the FSM go to 0 / IDLE.
  - rst overrides every same-cycle request, including mid-sequence immediates.
- Reads are combinational, with zero latency.
  - With BYPASS=1 and wr_en, a port whose select equals wr_sel returns wr_data.
  - Otherwise the port returns the stored value.
- Write: on wr_en, reg[wr_sel] <= wr_data at the edge.
- Immediate FSM (only meaningful when WIDTH>15; when WIDTH<=15, imm_hi is ignored and A <= imm_data[WIDTH-1:0] in one cycle):
  - IDLE, imm_valid & !imm_hi: A <= zero-extended imm_data. Go to LO_PEND; imm_pend=1.
  - LO_PEND, imm_valid & imm_hi: A[WIDTH-1:15] <= imm_data[WIDTH-16:0]; A[14:0] unchanged. Go to IDLE.
  - LO_PEND, imm_valid & !imm_hi: new low load, stay in LO_PEND.
  - LO_PEND, cycle without imm_valid: go to IDLE; A keeps its low value.
  - IDLE, imm_valid & imm_hi: ignored (no state change, A unchanged).
  - LO_PEND, any write to A (wr_en, wr_sel=A): go to IDLE.
- SP unit, operating on reg[REG_SP]:
  - push: SP <= SP-1; sp_addr = SP-1 (combinational).
  - pop: SP <= SP+1; sp_addr = SP.
  - none: sp_addr = SP.
  - Arithmetic wraps modulo 2^WIDTH.
  - sp_wrap set on push from 0 or pop from all-ones.
  - sp_wrap cleared only by rst or by a wr_en write to SP.
- Priority per register, high to low:
  - rst, then wr_en, then imm, then sp_op.
  - A losing request is dropped, with no partial effect; e.g. wr_en to SP plus a push gives SP = wr_data and sp_wrap cleared.
  - Requests aimed at different registers in the same cycle all take effect.
- Register roles: A=0, D=1, SP=2, RA=3. Registers 4..NREGS-1 are general purpose and writable only via wr_en.

Decomposition:
- Package regfile_pkg:
  - REG_A/REG_D/REG_SP/REG_RA index constants.
  - sp_op_e enum (SP_NONE, SP_PUSH, SP_POP).
  - imm_state_e enum (IMM_IDLE, IMM_LO_PEND).
- Sub-module regfile_sp_unit:
  - next-SP, sp_addr and wrap-detect logic, parameterised on WIDTH.
- The immediate FSM and the storage array stay in the top module.

Test Plan:
- rst, then idle reads of all selects -> 0. Write D=0x1234, then read D on rx -> 0x1234 the next cycle.
- BYPASS=1: wr_en, wr_sel=D, wr_data=0xBEEF, rx_sel=D in the same cycle -> rx_data=0xBEEF combinationally. BYPASS=0 -> rx_data is the old value.
- WIDTH=32, low-phase imm 0x7FFF then high-phase imm 0x0003 -> A=0x0001FFFF. Inserting an idle cycle between the phases -> A=0x00007FFF and imm_pend=0.
- SP=0, push -> sp_addr=0xFFFF, SP=0xFFFF, sp_wrap=1. Then pop -> sp_addr=0xFFFF, SP=0, sp_wrap stays 1. Then write SP=0x0100 -> sp_wrap=0.
- Same cycle: wr_en to SP=0x0040 plus push -> SP=0x0040. wr_en to D plus imm to A -> both updated.
- rst asserted while imm_pend=1 and a push is requested -> all registers 0, FSM IDLE, sp_wrap 0.

Source files
------------

// File: rtl/regfile_gen_pkg.sv
// rtl/regfile_gen_pkg.sv - shared constants and enums for the parametrised register file
package regfile_pkg;

    // Fixed register roles; indices 4..NREGS-1 are general purpose
    localparam int REG_A  = 0;
    localparam int REG_D  = 1;
    localparam int REG_SP = 2;
    localparam int REG_RA = 3;

    // Width of the immediate payload carried by one instruction word
    localparam int IMM_W = 15;

    // Encoding 2'b11 is reserved and behaves as SP_NONE
    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10
    } sp_op_e;

    typedef enum logic {
        IMM_IDLE    = 1'b0,
        IMM_LO_PEND = 1'b1
    } imm_state_e;

endpackage

// File: rtl/regfile_gen_if.sv
// rtl/regfile_gen_if.sv - decoder/ALU facing bundle of the register file
interface regfile_gen_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
);
    localparam int SW = $clog2(NREGS);

    logic [SW-1:0]    rx_sel;
    logic [SW-1:0]    ry_sel;
    logic [SW-1:0]    t_sel;
    logic             wr_en;
    logic [SW-1:0]    wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             imm_valid;
    logic             imm_hi;
    logic [14:0]      imm_data;
    logic [1:0]       sp_op;

    logic [WIDTH-1:0] rx_data;
    logic [WIDTH-1:0] ry_data;
    logic [WIDTH-1:0] t_data;
    logic [WIDTH-1:0] sp_data;
    logic [WIDTH-1:0] sp_addr;
    logic             sp_wrap;
    logic             imm_pend;

    // Decoder/ALU side
    modport master (
        output rx_sel, ry_sel, t_sel, wr_en, wr_sel, wr_data,
        output imm_valid, imm_hi, imm_data, sp_op,
        input  rx_data, ry_data, t_data, sp_data, sp_addr, sp_wrap, imm_pend
    );

    // Register file side
    modport slave (
        input  rx_sel, ry_sel, t_sel, wr_en, wr_sel, wr_data,
        input  imm_valid, imm_hi, imm_data, sp_op,
        output rx_data, ry_data, t_data, sp_data, sp_addr, sp_wrap, imm_pend
    );

endinterface

// File: rtl/regfile_gen_sp_unit.sv
// rtl/regfile_gen_sp_unit.sv - stack pointer next-value, address and wrap detection
module regfile_sp_unit
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sp_i,
    input  logic [1:0]       sp_op_i,
    output logic [WIDTH-1:0] sp_next_o,
    output logic [WIDTH-1:0] sp_addr_o,
    output logic             wrap_o
);

    // Push pre-decrements (address is the new SP), pop post-increments
    // (address is the current SP); both wrap modulo 2^WIDTH.
    always_comb begin
        sp_next_o = sp_i;
        sp_addr_o = sp_i;
        wrap_o    = 1'b0;
        case (sp_op_i)
            SP_PUSH: begin
                sp_next_o = sp_i - 1'b1;
                sp_addr_o = sp_i - 1'b1;
                wrap_o    = (sp_i == '0);
            end
            SP_POP: begin
                sp_next_o = sp_i + 1'b1;
                sp_addr_o = sp_i;
                wrap_o    = (sp_i == '1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_gen.sv
// rtl/regfile_gen.sv - parametrised register file with bypass, wide immediate and SP unit
module regfile_gen
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_gen_if.slave bus
);

    localparam int             SW       = $clog2(NREGS);
    localparam logic [SW-1:0]  SEL_A    = SW'(REG_A);
    localparam logic [SW-1:0]  SEL_SP   = SW'(REG_SP);
    localparam bit             WIDE_IMM = (WIDTH > IMM_W);
    localparam int             HI_W     = WIDE_IMM ? (WIDTH - IMM_W) : 1;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    imm_state_e       state_q;
    logic             imm_pend_q;
    logic             sp_wrap_q;

    logic [WIDTH-1:0] sp_next;
    logic [WIDTH-1:0] sp_addr;
    logic             sp_wrap_evt;
    logic             wr_a;
    logic             wr_sp;
    logic             imm_lo_load;
    logic             imm_hi_load;
    logic [WIDTH-1:0] imm_lo_val;
    logic [WIDTH-1:0] imm_hi_val;

    regfile_sp_unit #(.WIDTH(WIDTH)) u_sp (
        .sp_i      (regs_q[REG_SP]),
        .sp_op_i   (bus.sp_op),
        .sp_next_o (sp_next),
        .sp_addr_o (sp_addr),
        .wrap_o    (sp_wrap_evt)
    );

    assign wr_a  = bus.wr_en && (bus.wr_sel == SEL_A);
    assign wr_sp = bus.wr_en && (bus.wr_sel == SEL_SP);

    // Narrow files take the whole (truncated) payload in one cycle; wide
    // files only accept the high phase right after a low phase.
    assign imm_lo_load = bus.imm_valid && (!WIDE_IMM || !bus.imm_hi);
    assign imm_hi_load = WIDE_IMM && bus.imm_valid && bus.imm_hi &&
                         (state_q == IMM_LO_PEND);

    assign imm_lo_val = WIDTH'(bus.imm_data);

    // High phase fills A[WIDTH-1:15] and keeps the low 15 bits already loaded
    if (WIDE_IMM) begin : g_wide_imm
        assign imm_hi_val = {HI_W'(bus.imm_data), regs_q[REG_A][IMM_W-1:0]};
    end else begin : g_narrow_imm
        assign imm_hi_val = regs_q[REG_A];
    end

    // Next-state for storage: SP op lowest, then immediate, then the write port
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        regs_d[REG_SP] = sp_next;
        if (imm_lo_load) begin
            regs_d[REG_A] = imm_lo_val;
        end else if (imm_hi_load) begin
            regs_d[REG_A] = imm_hi_val;
        end
        if (bus.wr_en) begin
            regs_d[bus.wr_sel] = bus.wr_data;
        end
    end

    // Storage array update
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Sticky wrap flag; an explicit SP write both wins over the op and clears it
    always_ff @(posedge clk) begin
        if (rst || wr_sp) begin
            sp_wrap_q <= 1'b0;
        end else if (sp_wrap_evt) begin
            sp_wrap_q <= 1'b1;
        end
    end

    // Immediate phase tracker; a write to A cancels a pending high phase
    always_ff @(posedge clk) begin
        if (rst || !WIDE_IMM || wr_a) begin
            state_q    <= IMM_IDLE;
            imm_pend_q <= 1'b0;
        end else if (bus.imm_valid && !bus.imm_hi) begin
            state_q    <= IMM_LO_PEND;
            imm_pend_q <= 1'b1;
        end else begin
            state_q    <= IMM_IDLE;
            imm_pend_q <= 1'b0;
        end
    end

    // Combinational read ports with optional same-cycle write forwarding
    always_comb begin
        bus.rx_data = regs_q[bus.rx_sel];
        bus.ry_data = regs_q[bus.ry_sel];
        bus.t_data  = regs_q[bus.t_sel];
        if (BYPASS != 0 && bus.wr_en) begin
            if (bus.wr_sel == bus.rx_sel) bus.rx_data = bus.wr_data;
            if (bus.wr_sel == bus.ry_sel) bus.ry_data = bus.wr_data;
            if (bus.wr_sel == bus.t_sel)  bus.t_data  = bus.wr_data;
        end
    end

    assign bus.sp_data  = regs_q[REG_SP];
    assign bus.sp_addr  = sp_addr;
    assign bus.sp_wrap  = sp_wrap_q;
    assign bus.imm_pend = imm_pend_q;

endmodule

// File: tb/tb_regfile_gen.sv
// tb/tb_regfile_gen.sv - directed self-checking bench for regfile_gen
module tb_regfile_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    regfile_gen_if #(.WIDTH(16), .NREGS(4)) if16 ();
    regfile_gen_if #(.WIDTH(32), .NREGS(8)) if32 ();

    regfile_gen #(.WIDTH(16), .NREGS(4), .BYPASS(1)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    regfile_gen #(.WIDTH(32), .NREGS(8), .BYPASS(0)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (if32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        if16.rx_sel = '0; if16.ry_sel = '0; if16.t_sel = '0;
        if16.wr_en = 1'b0; if16.wr_sel = '0; if16.wr_data = '0;
        if16.imm_valid = 1'b0; if16.imm_hi = 1'b0; if16.imm_data = '0; if16.sp_op = 2'b00;
        if32.rx_sel = '0; if32.ry_sel = '0; if32.t_sel = '0;
        if32.wr_en = 1'b0; if32.wr_sel = '0; if32.wr_data = '0;
        if32.imm_valid = 1'b0; if32.imm_hi = 1'b0; if32.imm_data = '0; if32.sp_op = 2'b00;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state on every port of the 16-bit file
        for (int i = 0; i < 4; i++) begin
            if16.rx_sel = 2'(i); if16.ry_sel = 2'(i); if16.t_sel = 2'(i);
            #1;
            chk("rst_rx", if16.rx_data, 32'h0);
            chk("rst_ry", if16.ry_data, 32'h0);
            chk("rst_t",  if16.t_data,  32'h0);
        end
        chk("rst_pend", if16.imm_pend, 32'h0);
        chk("rst_wrap", if16.sp_wrap,  32'h0);

        // Plain write, read back next cycle
        clr(); if16.wr_en = 1'b1; if16.wr_sel = 2'd1; if16.wr_data = 16'h1234;
        tick(); clr(); if16.rx_sel = 2'd1; #1;
        chk("wr_d", if16.rx_data, 32'h1234);

        // Same-cycle forwarding only on the matching port
        if16.wr_en = 1'b1; if16.wr_sel = 2'd1; if16.wr_data = 16'hBEEF;
        if16.rx_sel = 2'd1; if16.ry_sel = 2'd0; #1;
        chk("bypass_rx", if16.rx_data, 32'hBEEF);
        chk("bypass_ry_other", if16.ry_data, 32'h0);
        tick(); clr();

        // Push from zero wraps
        if16.sp_op = 2'b01; #1;
        chk("push0_addr", if16.sp_addr, 32'hFFFF);
        tick(); clr(); #1;
        chk("push0_sp", if16.sp_data, 32'hFFFF);
        chk("push0_wrap", if16.sp_wrap, 32'h1);

        // Pop back to zero, flag stays sticky
        if16.sp_op = 2'b10; #1;
        chk("pop_addr", if16.sp_addr, 32'hFFFF);
        tick(); clr();
        chk("pop_sp", if16.sp_data, 32'h0);
        chk("pop_wrap_sticky", if16.sp_wrap, 32'h1);

        // Writing SP clears the flag; sp_data is never forwarded
        if16.wr_en = 1'b1; if16.wr_sel = 2'd2; if16.wr_data = 16'h0100; #1;
        chk("sp_no_bypass", if16.sp_data, 32'h0);
        tick(); clr();
        chk("wr_sp", if16.sp_data, 32'h0100);
        chk("wr_sp_clr_wrap", if16.sp_wrap, 32'h0);

        // Write to SP beats a push
        if16.wr_en = 1'b1; if16.wr_sel = 2'd2; if16.wr_data = 16'h0040; if16.sp_op = 2'b01;
        tick(); clr();
        chk("wr_beats_push", if16.sp_data, 32'h0040);

        // Write to D and immediate to A both land
        if16.wr_en = 1'b1; if16.wr_sel = 2'd1; if16.wr_data = 16'h5555;
        if16.imm_valid = 1'b1; if16.imm_data = 15'h0123;
        tick(); clr(); if16.rx_sel = 2'd1; if16.t_sel = 2'd0; #1;
        chk("dual_d", if16.rx_data, 32'h5555);
        chk("dual_a", if16.t_data, 32'h0123);
        chk("dual_pend", if16.imm_pend, 32'h1);

        // High phase on a 16-bit file sets A[15] from imm_data[0]
        if16.imm_valid = 1'b1; if16.imm_hi = 1'b1; if16.imm_data = 15'h0001;
        tick(); clr(); #1;
        chk("hi16_a", if16.t_data, 32'h8123);
        chk("hi16_pend", if16.imm_pend, 32'h0);

        // Ordinary push
        if16.sp_op = 2'b01; #1;
        chk("push_addr", if16.sp_addr, 32'h003F);
        tick(); clr();
        chk("push_sp", if16.sp_data, 32'h003F);

        // Reset in the middle of an immediate with competing requests
        if16.wr_en = 1'b1; if16.wr_sel = 2'd2; if16.wr_data = 16'h0000;
        tick(); clr(); if16.sp_op = 2'b01;
        tick(); clr();
        chk("pre_rst_wrap", if16.sp_wrap, 32'h1);
        if16.imm_valid = 1'b1; if16.imm_data = 15'h0011;
        tick(); clr();
        chk("pre_rst_pend", if16.imm_pend, 32'h1);
        rst = 1'b1; if16.sp_op = 2'b01; if16.imm_valid = 1'b1; if16.imm_hi = 1'b1;
        if16.wr_en = 1'b1; if16.wr_sel = 2'd1; if16.wr_data = 16'h9999;
        tick(); rst = 1'b0; clr();
        for (int i = 0; i < 4; i++) begin
            if16.rx_sel = 2'(i); #1;
            chk("rst2_reg", if16.rx_data, 32'h0);
        end
        chk("rst2_pend", if16.imm_pend, 32'h0);
        chk("rst2_wrap", if16.sp_wrap, 32'h0);
        clr();

        // 32-bit file, no forwarding
        if32.wr_en = 1'b1; if32.wr_sel = 3'd1; if32.wr_data = 32'h1234;
        tick(); clr();
        if32.wr_en = 1'b1; if32.wr_sel = 3'd1; if32.wr_data = 32'hBEEF; if32.rx_sel = 3'd1; #1;
        chk("nobypass_old", if32.rx_data, 32'h1234);
        tick(); clr(); if32.rx_sel = 3'd1; #1;
        chk("nobypass_new", if32.rx_data, 32'hBEEF);

        // Two-phase immediate
        clr(); if32.imm_valid = 1'b1; if32.imm_data = 15'h7FFF;
        tick(); clr();
        chk("imm32_pend", if32.imm_pend, 32'h1);
        if32.imm_valid = 1'b1; if32.imm_hi = 1'b1; if32.imm_data = 15'h0003;
        tick(); clr(); #1;
        chk("imm32_a", if32.t_data, 32'h0001FFFF);
        chk("imm32_done", if32.imm_pend, 32'h0);

        // Idle cycle between phases drops the high phase
        if32.imm_valid = 1'b1; if32.imm_data = 15'h7FFF;
        tick(); clr(); tick();
        chk("gap_pend", if32.imm_pend, 32'h0);
        if32.imm_valid = 1'b1; if32.imm_hi = 1'b1; if32.imm_data = 15'h0003;
        tick(); clr(); #1;
        chk("gap_a", if32.t_data, 32'h00007FFF);

        // Write to A during a pending immediate wins and cancels it
        if32.imm_valid = 1'b1; if32.imm_data = 15'h0010;
        tick(); clr();
        if32.wr_en = 1'b1; if32.wr_sel = 3'd0; if32.wr_data = 32'hCAFE;
        if32.imm_valid = 1'b1; if32.imm_hi = 1'b1; if32.imm_data = 15'h0005;
        tick(); clr(); #1;
        chk("wra_a", if32.t_data, 32'h0000CAFE);
        chk("wra_pend", if32.imm_pend, 32'h0);

        // General purpose register
        if32.wr_en = 1'b1; if32.wr_sel = 3'd5; if32.wr_data = 32'hDEADBEEF;
        tick(); clr(); if32.ry_sel = 3'd5; #1;
        chk("gp5", if32.ry_data, 32'hDEADBEEF);

        // Pop from all-ones wraps
        clr(); if32.wr_en = 1'b1; if32.wr_sel = 3'd2; if32.wr_data = 32'hFFFFFFFF;
        tick(); clr(); if32.sp_op = 2'b10; #1;
        chk("pop1_addr", if32.sp_addr, 32'hFFFFFFFF);
        tick(); clr();
        chk("pop1_sp", if32.sp_data, 32'h0);
        chk("pop1_wrap", if32.sp_wrap, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
